// File: rtl/instr_ram_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: owner of the access whose read data is in flight.
package instr_ram_arbiter_pkg;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_CORE = 2'd1,
      OWNER_BUS  = 2'd2
   } arb_owner_e;

   function automatic arb_owner_e owner_from_grants(input logic core_gnt, input logic bus_gnt);
      if (core_gnt)     return OWNER_CORE;
      else if (bus_gnt) return OWNER_BUS;
      else              return OWNER_NONE;
   endfunction

endpackage

// File: rtl/instr_arb_prio_sel.sv
// Winner selection between core fetch and bus port. Default build: fixed core priority with a bus
// starvation counter. With INSTR_ARB_ROUND_ROBIN_EN defined, conflicts alternate via a last-grant bit.
module instr_arb_prio_sel
   import instr_ram_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic       i_core_req,
   input  logic       i_bus_req,
   output arb_owner_e o_winner
);

   logic w_bus_win;
   logic w_core_win;

`ifdef INSTR_ARB_ROUND_ROBIN_EN
   // Reset to "core granted last" so the bus takes the first conflict.
   logic r_last_bus;

   always_comb begin
      w_bus_win  = i_en && i_bus_req && (!i_core_req || !r_last_bus);
      w_core_win = i_en && i_core_req && !w_bus_win;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          r_last_bus <= 1'b0;
      else if (w_bus_win)  r_last_bus <= 1'b1;
      else if (w_core_win) r_last_bus <= 1'b0;
   end
`else
   localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] r_wait_cnt;

   always_comb begin
      w_bus_win  = i_en && i_bus_req && (!i_core_req || (r_wait_cnt == MAX_CNT));
      w_core_win = i_en && i_core_req && !w_bus_win;
   end

   // Counts cycles the bus has been refused; holds at MAX_CNT until the forced grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_wait_cnt <= '0;
      else if (!i_bus_req || w_bus_win) r_wait_cnt <= '0;
      else if (r_wait_cnt != MAX_CNT)   r_wait_cnt <= r_wait_cnt + 1'b1;
   end
`endif

   assign o_winner = owner_from_grants(w_core_win, w_bus_win);

endmodule

// File: rtl/instr_ram_arbiter.sv
// Single-port instruction memory arbiter (core fetch vs bus/loader) with response routing and
// boot-ROM write protection. Optional build macro: INSTR_ARB_ROUND_ROBIN_EN (alternating conflicts).
module instr_ram_arbiter
   import instr_ram_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    core_req_i,
   input  logic [ADDR_WIDTH-1:0]   core_addr_i,
   output logic                    core_gnt_o,
   output logic                    core_rvalid_o,
   output logic [DATA_WIDTH-1:0]   core_rdata_o,
   input  logic                    bus_req_i,
   input  logic                    bus_we_i,
   input  logic [DATA_WIDTH/8-1:0] bus_be_i,
   input  logic [ADDR_WIDTH-1:0]   bus_addr_i,
   input  logic [DATA_WIDTH-1:0]   bus_wdata_i,
   output logic                    bus_gnt_o,
   output logic                    bus_rvalid_o,
   output logic [DATA_WIDTH-1:0]   bus_rdata_o,
   output logic                    bus_err_o,
   output logic                    ram_en_o,
   output logic [ADDR_WIDTH-1:0]   ram_addr_o,
   output logic                    ram_we_o,
   output logic [DATA_WIDTH/8-1:0] ram_be_o,
   output logic [DATA_WIDTH-1:0]   ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

   arb_owner_e w_winner;
   logic       w_core_gnt;
   logic       w_bus_gnt;
   logic       w_boot_wr;
   logic       w_bus_ram;
   arb_owner_e r_owner_p1;
   logic       r_err_p1;

   // Grants are suppressed while reset is held so every output reads 0 during reset.
   instr_arb_prio_sel #(
      .MAX_WAIT (MAX_WAIT)
   ) u_prio_sel (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (rst_n),
      .i_core_req (core_req_i),
      .i_bus_req  (bus_req_i),
      .o_winner   (w_winner)
   );

   assign w_core_gnt = (w_winner == OWNER_CORE);
   assign w_bus_gnt  = (w_winner == OWNER_BUS);
   assign w_boot_wr  = bus_we_i && bus_addr_i[ADDR_WIDTH-1];
   assign w_bus_ram  = w_bus_gnt && !w_boot_wr;

   assign core_gnt_o  = w_core_gnt;
   assign bus_gnt_o   = w_bus_gnt;

   assign ram_en_o    = w_core_gnt || w_bus_ram;
   assign ram_addr_o  = w_core_gnt ? core_addr_i : (w_bus_gnt ? bus_addr_i : '0);
   assign ram_we_o    = w_bus_ram && bus_we_i;
   assign ram_be_o    = w_bus_ram ? bus_be_i : '0;
   assign ram_wdata_o = w_bus_ram ? bus_wdata_i : '0;

   // Memory read-latency stage: remembers who owns the data arriving next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner_p1 <= OWNER_NONE;
         r_err_p1   <= 1'b0;
      end else begin
         r_owner_p1 <= w_winner;
         r_err_p1   <= w_bus_gnt && w_boot_wr;
      end
   end

   assign core_rvalid_o = (r_owner_p1 == OWNER_CORE);
   assign bus_rvalid_o  = (r_owner_p1 == OWNER_BUS);
   assign core_rdata_o  = core_rvalid_o ? ram_rdata_i : '0;
   assign bus_rdata_o   = bus_rvalid_o ? ram_rdata_i : '0;
   assign bus_err_o     = bus_rvalid_o && r_err_p1;

endmodule
